i2c_write_queue: RTL and testbench

//   Upstream command stage for the I2C master. Buffers register-write requests
//   (7-bit slave address, 8-bit data) from the robot control logic in a small

---
 rtl/i2c_write_queue.sv | 123 ++++++++++++
 tb/tb_i2c_write_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_queue.sv
// i2c_write_queue: FIFO of (addr, data) register writes in front of the I2C master.
// Launches one entry at a time, waits for done, and aborts hung transfers.
module i2c_write_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [6:0]             req_addr,
    input  logic [7:0]             req_data,
    output logic                   i2c_start,
    output logic [6:0]             i2c_slave_addr,
    output logic [7:0]             i2c_data,
    input  logic                   i2c_busy,
    input  logic                   i2c_done,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [14:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic [15:0]   r_timer;
    logic          r_start;
    logic [6:0]    r_addr;
    logic [7:0]    r_data;
    logic          r_terr;

    logic w_push;
    logic w_launch;
    logic w_done;
    logic w_abort;
    logic w_pop;

    // Handshake and FSM event decode from registered state.
    always_comb begin
        w_push   = req_valid && (r_count < FULL);
        w_launch = (r_state == S_IDLE) && (r_count != '0) && !i2c_busy;
        w_done   = (r_state == S_WAIT) && i2c_done;
        w_abort  = (r_state == S_WAIT) && !i2c_done && (r_timer == TMO);
        w_pop    = w_done || w_abort;
    end

    // Storage array; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_addr, req_data};
        end
    end

    // Pointers and occupancy; the head leaves only on completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch/wait FSM with registered outputs; operands stay frozen in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_terr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_addr  <= r_mem[r_rd_ptr][14:8];
                        r_data  <= r_mem[r_rd_ptr][7:0];
                        r_start <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else if (w_abort) begin
                        r_terr  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
            endcase
        end
    end

    assign req_ready      = (r_count < FULL);
    assign i2c_start      = r_start;
    assign i2c_slave_addr = r_addr;
    assign i2c_data       = r_data;
    assign pending        = r_count;
    assign timeout_err    = r_terr;

endmodule

// File: tb/tb_i2c_write_queue.sv
// Directed bench for i2c_write_queue: vector table plus hand-written
// sequences for burst fill, hung master, done/timeout race and reset.
module tb_i2c_write_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       valid = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data = '0;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic       ready;
    logic       start;
    logic [6:0] saddr;
    logic [7:0] sdata;
    logic [2:0] pend;
    logic       terr;

    logic       t_valid = 1'b0;
    logic [6:0] t_addr = '0;
    logic [7:0] t_data = '0;
    logic       t_busy = 1'b0;
    logic       t_done = 1'b0;
    logic       t_ready;
    logic       t_start;
    logic [6:0] t_saddr;
    logic [7:0] t_sdata;
    logic [2:0] t_pend;
    logic       t_terr;

    int n_checks = 0;
    int n_fail = 0;
    logic [14:0] issued[$];

    always #5 clk = ~clk;

    i2c_write_queue #(.DEPTH(4), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid), .req_ready(ready),
        .req_addr(addr), .req_data(data),
        .i2c_start(start), .i2c_slave_addr(saddr), .i2c_data(sdata),
        .i2c_busy(busy), .i2c_done(done),
        .pending(pend), .timeout_err(terr)
    );

    i2c_write_queue #(.DEPTH(4), .TIMEOUT(10)) u_tmo (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_valid), .req_ready(t_ready),
        .req_addr(t_addr), .req_data(t_data),
        .i2c_start(t_start), .i2c_slave_addr(t_saddr), .i2c_data(t_sdata),
        .i2c_busy(t_busy), .i2c_done(t_done),
        .pending(t_pend), .timeout_err(t_terr)
    );

    // Record every launch of the main instance for order checking.
    always @(negedge clk) begin
        if (rst_n && start) issued.push_back({saddr, sdata});
    end

    typedef struct {
        logic       v;
        logic [6:0] a;
        logic [7:0] d;
        logic       b;
        logic       dn;
        logic       e_start;
        logic [6:0] e_addr;
        logic [7:0] e_data;
        logic [2:0] e_pend;
        logic       e_ready;
        logic       e_terr;
    } vec_t;

    function automatic vec_t mk(logic v, logic [6:0] a, logic [7:0] d,
                                logic b, logic dn, logic es,
                                logic [6:0] ea, logic [7:0] ed,
                                logic [2:0] ep, logic er, logic et);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.b = b; r.dn = dn;
        r.e_start = es; r.e_addr = ea; r.e_data = ed;
        r.e_pend = ep; r.e_ready = er; r.e_terr = et;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0; done = 1'b0; busy = 1'b0;
        t_valid = 1'b0; t_done = 1'b0; t_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issued.delete();
    endtask

    task automatic wait_start(string nm);
        int n = 0;
        while (start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(start), 32'd1);
    endtask

    vec_t tbl[13];
    logic [14:0] exp_q[5];

    initial begin
        int bad;

        // Reset values
        do_reset();
        chk("rst start", 32'(start), 0);
        chk("rst addr", 32'(saddr), 0);
        chk("rst data", 32'(sdata), 0);
        chk("rst pending", 32'(pend), 0);
        chk("rst ready", 32'(ready), 1);
        chk("rst terr", 32'(terr), 0);

        // Vector table: inputs before an edge, outputs after it
        tbl[0]  = mk(1'b1, 7'h11, 8'hA1, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 7'h22, 8'hB2, 1'b0, 1'b0, 1'b1, 7'h11, 8'hA1, 3'd2, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 7'h33, 8'hC3, 1'b0, 1'b0, 1'b0, 7'h11, 8'hA1, 3'd3, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h11, 8'hA1, 3'd2, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 1'b0, 7'h11, 8'hA1, 3'd2, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 7'h22, 8'hB2, 3'd2, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 7'h44, 8'hD4, 1'b0, 1'b1, 1'b0, 7'h22, 8'hB2, 3'd2, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 7'h33, 8'hC3, 3'd2, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h33, 8'hC3, 3'd1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 7'h44, 8'hD4, 3'd1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h44, 8'hD4, 3'd0, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0, 7'h44, 8'hD4, 3'd0, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0, 7'h44, 8'hD4, 3'd0, 1'b1, 1'b0);

        for (int i = 0; i < 13; i++) begin
            valid = tbl[i].v; addr = tbl[i].a; data = tbl[i].d;
            busy = tbl[i].b; done = tbl[i].dn;
            step();
            chk($sformatf("v%0d start", i), 32'(start), 32'(tbl[i].e_start));
            chk($sformatf("v%0d addr", i), 32'(saddr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d data", i), 32'(sdata), 32'(tbl[i].e_data));
            chk($sformatf("v%0d pending", i), 32'(pend), 32'(tbl[i].e_pend));
            chk($sformatf("v%0d ready", i), 32'(ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d terr", i), 32'(terr), 32'(tbl[i].e_terr));
        end
        valid = 1'b0; done = 1'b0; busy = 1'b0;

        // Single write, done 20 cycles after launch
        do_reset();
        valid = 1'b1; addr = 7'h2A; data = 8'h5C;
        step();
        valid = 1'b0;
        chk("single pend1", 32'(pend), 1);
        chk("single no early start", 32'(start), 0);
        step();
        chk("single start", 32'(start), 1);
        chk("single addr", 32'(saddr), 32'h2A);
        chk("single data", 32'(sdata), 32'h5C);
        bad = 0;
        for (int k = 0; k < 19; k++) begin
            step();
            if (start !== 1'b0 || saddr !== 7'h2A || sdata !== 8'h5C
                || pend !== 3'd1) bad++;
        end
        chk("single hold", 32'(bad), 0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single pend0", 32'(pend), 0);
        repeat (3) step();
        chk("single one launch", 32'(issued.size()), 1);

        // Burst fill: 5 requests into a 4-deep queue
        do_reset();
        exp_q[0] = {7'h01, 8'h10};
        exp_q[1] = {7'h02, 8'h20};
        exp_q[2] = {7'h03, 8'h30};
        exp_q[3] = {7'h04, 8'h40};
        exp_q[4] = {7'h05, 8'h50};
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            {addr, data} = exp_q[i];
            step();
        end
        chk("burst pend4", 32'(pend), 4);
        chk("burst full ready", 32'(ready), 0);
        {addr, data} = exp_q[4];
        repeat (2) step();
        chk("burst 5th held", 32'(pend), 4);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("burst pop pend3", 32'(pend), 3);
        chk("burst ready again", 32'(ready), 1);
        step();
        valid = 1'b0;
        chk("burst 5th stored", 32'(pend), 4);
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("burst launch %0d", i + 1));
            done = 1'b1;
            step();
            done = 1'b0;
        end
        repeat (4) step();
        chk("burst pend end", 32'(pend), 0);
        chk("burst launches", 32'(issued.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < issued.size())
                chk($sformatf("burst order %0d", i), 32'(issued[i]), 32'(exp_q[i]));
        end

        // Hung master on the TIMEOUT=10 instance
        do_reset();
        t_valid = 1'b1; t_addr = 7'h6A; t_data = 8'h01;
        step();
        t_addr = 7'h6B; t_data = 8'h02;
        step();
        t_valid = 1'b0;
        chk("hung start", 32'(t_start), 1);
        chk("hung addr", 32'(t_saddr), 32'h6A);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (t_terr !== 1'b0 || t_pend !== 3'd2) bad++;
        end
        chk("hung no early abort", 32'(bad), 0);
        step();
        chk("hung terr", 32'(t_terr), 1);
        chk("hung popped", 32'(t_pend), 1);
        step();
        chk("hung terr pulse", 32'(t_terr), 0);
        chk("hung next start", 32'(t_start), 1);
        chk("hung next addr", 32'(t_saddr), 32'h6B);
        chk("hung next data", 32'(t_sdata), 32'h02);

        // Done on the same cycle the timer reaches TIMEOUT
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (t_terr !== 1'b0) bad++;
        end
        chk("race no early abort", 32'(bad), 0);
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        chk("race terr", 32'(t_terr), 0);
        chk("race popped", 32'(t_pend), 0);
        step();
        chk("race terr after", 32'(t_terr), 0);
        chk("race no relaunch", 32'(t_start), 0);

        // Reset while a transfer is in flight with 3 queued
        do_reset();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            {addr, data} = exp_q[i];
            step();
        end
        valid = 1'b0;
        step();
        chk("mid pend3", 32'(pend), 3);
        chk("mid addr", 32'(saddr), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst pend", 32'(pend), 0);
        chk("mid rst start", 32'(start), 0);
        chk("mid rst addr", 32'(saddr), 0);
        chk("mid rst data", 32'(sdata), 0);
        chk("mid rst ready", 32'(ready), 1);
        #3;
        rst_n = 1'b1;
        issued.delete();
        repeat (5) step();
        chk("mid no launch", 32'(issued.size()), 0);
        chk("mid pend after", 32'(pend), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
